// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback port arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 issue_stall,
  output logic                 regWrite,
  output logic [AW-1:0]        rd,
  output logic [XLEN-1:0]      writeData
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;
  logic [PW-1:0]   ptr_q, ptr_d, g, c;
  logic            hs, set;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic [NR-1:0]   busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  // Grant the first valid requester found scanning upward from ptr, wrapping
  always_comb begin
    hs = 1'b0;
    g = '0;
    c = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = PW'((int'(ptr_q) + k) % NREQ);
      if (!hs && req_valid[c]) begin
        hs = 1'b1;
        g = c;
      end
    end
  end
  assign req_ready   = hs ? NREQ'(1) << g : '0;
  assign g_rd        = req_rd[int'(g)*AW +: AW];
  assign g_data      = req_data[int'(g)*XLEN +: XLEN];
  assign issue_stall = issue_valid && issue_rd != '0 && busy_q[issue_rd];
  assign set         = issue_valid && !issue_stall && issue_rd != '0;
  assign rs1_busy    = busy_q[rs1];
  assign rs2_busy    = busy_q[rs2];
  assign regWrite    = we_q;
  assign rd          = rd_q;
  assign writeData   = wd_q;
  // Next pointer, write port and scoreboard; a same-register set overrides the clear
  always_comb begin
    ptr_d = hs ? PW'((int'(g) + 1) % NREQ) : ptr_q;
    we_d = hs && g_rd != '0;
    rd_d = hs ? g_rd : rd_q;
    wd_d = hs ? g_data : wd_q;
    busy_d = busy_q;
    if (we_d) busy_d[g_rd] = 1'b0;
    if (set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // State registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q  <= '0;
      busy_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks against a behavioural model
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy, issue_stall, regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  int checks = 0, errors = 0;
  bit [31:0] m_busy;
  int m_ptr;
  logic m_we;
  logic [4:0] m_rd;
  logic [31:0] m_wd;
  always #5 clk = ~clk;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_stall(issue_stall), .regWrite(regWrite),
    .rd(rd), .writeData(writeData)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction
  task automatic model_reset();
    m_busy = '0;
    m_ptr = 0;
    m_we = 1'b0;
    m_rd = '0;
    m_wd = '0;
  endtask
  task automatic step(input logic [2:0] v, input logic [4:0] r0, r1, r2,
                      input logic [31:0] d0, d1, d2, input logic iv,
                      input logic [4:0] ird, s1, s2);
    int gi;
    logic stall;
    logic [4:0] grd;
    req_valid = v; req_rd = {r2, r1, r0}; req_data = {d2, d1, d0};
    issue_valid = iv; issue_rd = ird; rs1 = s1; rs2 = s2;
    #1;
    gi = pick(v, m_ptr);
    stall = iv && ird != 0 && m_busy[ird];
    chk("req_ready", req_ready, gi < 0 ? 0 : (1 << gi));
    chk("rs1_busy", rs1_busy, m_busy[s1]);
    chk("rs2_busy", rs2_busy, m_busy[s2]);
    chk("issue_stall", issue_stall, stall);
    @(posedge clk);
    #1;
    if (gi >= 0) begin
      grd = gi == 0 ? r0 : gi == 1 ? r1 : r2;
      m_wd = gi == 0 ? d0 : gi == 1 ? d1 : d2;
      m_rd = grd;
      m_we = grd != 0;
      m_ptr = (gi + 1) % 3;
      if (grd != 0) m_busy[grd] = 1'b0;
    end else m_we = 1'b0;
    if (iv && !stall && ird != 0) m_busy[ird] = 1'b1;
    chk("regWrite", regWrite, m_we);
    chk("rd", rd, m_rd);
    chk("writeData", writeData, m_wd);
    chk("busy", dut.busy_q, m_busy);
    chk("ptr", dut.ptr_q, m_ptr);
  endtask
  initial begin
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    model_reset();
    #2;
    chk("reset_regWrite", regWrite, 0);
    chk("reset_rd", rd, 0);
    chk("reset_wd", writeData, 0);
    chk("reset_ready", req_ready, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    step(3'b001, 5'd3, 0, 0, 32'h1234_5678, 0, 0, 1'b1, 5'd5, 5'd5, 0);
    chk("t1_pre_busy5", rs1_busy, 1);
    chk("t1_pre_we", regWrite, 1);
    #2 rst = 1'b1;
    req_valid = '0; issue_valid = 1'b0;
    #1;
    model_reset();
    chk("t1_busy", dut.busy_q, 0);
    chk("t1_rs1_busy", rs1_busy, 0);
    chk("t1_we", regWrite, 0);
    chk("t1_ptr", dut.ptr_q, 0);
    chk("t1_rd", rd, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 5'd1, 5'd2, 5'd3, $urandom, $urandom, $urandom, 1'b0, 0, 0, 0);
      chk("t2_rd", rd, (i % 3) + 1);
      chk("t2_we", regWrite, 1);
    end
    step(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7, 0, 0);
    step(3'b010, 0, 5'd7, 0, 0, 32'hDEAD_BEEF, 0, 1'b0, 0, 5'd7, 0);
    chk("t3_we", regWrite, 1);
    chk("t3_rd", rd, 7);
    chk("t3_wd", writeData, 32'hDEAD_BEEF);
    chk("t3_rs1_clear", rs1_busy, 0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd12, 5'd12, 0);
    step(3'b001, 0, 0, 0, 32'hAAAA_5555, 0, 0, 1'b0, 0, 5'd12, 0);
    chk("t4_ptr", dut.ptr_q, 1);
    chk("t4_we", regWrite, 0);
    chk("t4_busy12", rs1_busy, 1);
    step(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd9, 0, 0);
    issue_valid = 1'b1; issue_rd = 5'd9; #1;
    chk("t5_stall_pre", issue_stall, 1);
    step(3'b010, 0, 5'd9, 0, 0, 32'h9, 0, 1'b1, 5'd9, 0, 0);
    chk("t5_cleared", dut.busy_q[9], 0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd9, 0, 0);
    chk("t5_set", dut.busy_q[9], 1);
    step(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd6, 0, 0);
    step(3'b111, 5'd6, 5'd6, 5'd6, 32'h66, 32'h66, 32'h66, 1'b1, 5'd4, 0, 0);
    chk("t6_busy4", dut.busy_q[4], 1);
    chk("t6_busy6", dut.busy_q[6], 0);
    for (int i = 0; i < 400; i++)
      step(3'($urandom_range(0, 7)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
